// File: rtl/mbist_march_engine_pkg.sv
// mbist_pkg: shared definitions for the parametrised MBIST march engine.
//   - TESTTYPE encodings for the three supported algorithms
//   - FSM state enum
//   - march element tables (op list, data polarity, direction, element count)
// No ports; imported by the engine top.
package mbist_pkg;

    localparam logic [2:0] TT_MSCAN  = 3'd0;
    localparam logic [2:0] TT_CHKB   = 3'd1;
    localparam logic [2:0] TT_MARCHC = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // One march element. twoOps means a second op is applied at the same
    // address before the address moves. rdN selects read-compare over write,
    // invN selects the inverted data background for that op.
    typedef struct packed {
        logic down;
        logic twoOps;
        logic rd0;
        logic inv0;
        logic rd1;
        logic inv1;
    } elem_t;

    // Number of elements in the selected algorithm.
    function automatic logic [2:0] elemCount(input logic [2:0] tt);
        return (tt == TT_MARCHC) ? 3'd6 : 3'd4;
    endfunction

    // Only the two middle March C- elements walk the address space downwards.
    function automatic logic elemDown(input logic [2:0] tt, input logic [2:0] idx);
        return (tt == TT_MARCHC) && ((idx == 3'd3) || (idx == 3'd4));
    endfunction

    // Element table lookup. Mscan and checkerboard share one table
    // (w, r, w~, r~); they differ only in the data background.
    function automatic elem_t elemLookup(input logic [2:0] tt, input logic [2:0] idx);
        elem_t e;
        e = '0;
        e.down = elemDown(tt, idx);
        if (tt == TT_MARCHC) begin
            case (idx)
                // (r0,w1)
                3'd1, 3'd3: begin
                    e.twoOps = 1'b1;
                    e.rd0    = 1'b1;
                    e.inv1   = 1'b1;
                end
                // (r1,w0)
                3'd2, 3'd4: begin
                    e.twoOps = 1'b1;
                    e.rd0    = 1'b1;
                    e.inv0   = 1'b1;
                end
                // final (r0)
                3'd5: e.rd0 = 1'b1;
                // (w0)
                default: e.rd0 = 1'b0;
            endcase
        end else begin
            e.rd0  = idx[0];
            e.inv0 = idx[1];
        end
        return e;
    endfunction

endpackage

// File: rtl/mbist_march_engine_if.sv
// mbist_march_engine_if: bundles the test-access control, memory-side bus and
// result signals of the MBIST march engine.
//   MBISTEN, TESTTYPE         test-access control into the engine
//   ADDR_MBIST, DATA_MBIST,
//   iWrite, iRead, DATA_DUT   single-port SRAM access
//   DONE, RESULT, FAIL_ADDR,
//   FAIL_DATA, FAIL_CNT       test results
// master = engine side, slave = test-access / memory side.
interface mbist_march_engine_if #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int CW = 8
);
    logic          MBISTEN;
    logic [2:0]    TESTTYPE;
    logic [AW-1:0] ADDR_MBIST;
    logic [DW-1:0] DATA_MBIST;
    logic          iWrite;
    logic          iRead;
    logic [DW-1:0] DATA_DUT;
    logic          DONE;
    logic          RESULT;
    logic [AW-1:0] FAIL_ADDR;
    logic [DW-1:0] FAIL_DATA;
    logic [CW-1:0] FAIL_CNT;

    modport master (
        input  MBISTEN, TESTTYPE, DATA_DUT,
        output ADDR_MBIST, DATA_MBIST, iWrite, iRead,
        output DONE, RESULT, FAIL_ADDR, FAIL_DATA, FAIL_CNT
    );

    modport slave (
        output MBISTEN, TESTTYPE, DATA_DUT,
        input  ADDR_MBIST, DATA_MBIST, iWrite, iRead,
        input  DONE, RESULT, FAIL_ADDR, FAIL_DATA, FAIL_CNT
    );
endinterface

// File: rtl/mbist_march_engine_cmp_pipe.sv
// mbist_cmp_pipe: read-compare path of the MBIST engine.
//   clk, nReset   clock, synchronous active-low reset
//   clear_i       start of a new test: clears results
//   flush_i       abort: drops reads still in flight
//   rdValid_i     read strobe issued this cycle
//   expData_i     expected data of that read
//   addr_i        address of that read
//   dataDut_i     memory read data, valid RD_LAT cycles after the strobe
//   failAddr_o    address of the first miscompare
//   failData_o    first syndrome (read data xor expected)
//   failCnt_o     saturating miscompare count
module mbist_cmp_pipe #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 1,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          clear_i,
    input  logic          flush_i,
    input  logic          rdValid_i,
    input  logic [DW-1:0] expData_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] dataDut_i,
    output logic [AW-1:0] failAddr_o,
    output logic [DW-1:0] failData_o,
    output logic [CW-1:0] failCnt_o
);

    logic          valid_q [RD_LAT];
    logic [DW-1:0] exp_q   [RD_LAT];
    logic [AW-1:0] addr_q  [RD_LAT];

    logic [AW-1:0] failAddr_q, failAddr_d;
    logic [DW-1:0] failData_q, failData_d;
    logic [CW-1:0] failCnt_q, failCnt_d;
    logic          firstSeen_q, firstSeen_d;

    logic [DW-1:0] syndrome;
    logic          miscompare;

    // Delay line: expected data and address travel alongside the read so
    // they line up with DATA_DUT. An abort wipes every valid bit at once.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                valid_q[i] <= 1'b0;
                exp_q[i]   <= '0;
                addr_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= rdValid_i && !flush_i;
            exp_q[0]   <= expData_i;
            addr_q[0]  <= addr_i;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1] && !flush_i;
                exp_q[i]   <= exp_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign syndrome   = dataDut_i ^ exp_q[RD_LAT-1];
    assign miscompare = valid_q[RD_LAT-1] && !flush_i && (syndrome != '0);

    // Result update: clear on start, otherwise count every miscompare
    // (saturating) and freeze address/syndrome of the first one.
    always_comb begin
        failAddr_d  = failAddr_q;
        failData_d  = failData_q;
        failCnt_d   = failCnt_q;
        firstSeen_d = firstSeen_q;
        if (clear_i) begin
            failAddr_d  = '0;
            failData_d  = '0;
            failCnt_d   = '0;
            firstSeen_d = 1'b0;
        end else if (miscompare) begin
            if (failCnt_q != '1) begin
                failCnt_d = failCnt_q + CW'(1);
            end
            if (!firstSeen_q) begin
                failAddr_d  = addr_q[RD_LAT-1];
                failData_d  = syndrome;
                firstSeen_d = 1'b1;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            failAddr_q  <= '0;
            failData_q  <= '0;
            failCnt_q   <= '0;
            firstSeen_q <= 1'b0;
        end else begin
            failAddr_q  <= failAddr_d;
            failData_q  <= failData_d;
            failCnt_q   <= failCnt_d;
            firstSeen_q <= firstSeen_d;
        end
    end

    assign failAddr_o = failAddr_q;
    assign failData_o = failData_q;
    assign failCnt_o  = failCnt_q;

endmodule

// File: rtl/mbist_march_engine.sv
// mbist_march_engine: generates Mscan, checkerboard and March C- sequences
// for a single-port SRAM and reports pass/fail, first-fail address/syndrome
// and a saturating fail count.
//   CLK     clock, all logic on the rising edge
//   nRESET  synchronous active-low reset
//   bus     mbist_march_engine_if.master: MBISTEN/TESTTYPE control,
//           ADDR_MBIST/DATA_MBIST/iWrite/iRead/DATA_DUT memory access,
//           DONE/RESULT/FAIL_ADDR/FAIL_DATA/FAIL_CNT results
module mbist_march_engine
    import mbist_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1,
    parameter int CW     = 8
) (
    input logic                 CLK,
    input logic                 nRESET,
    mbist_march_engine_if.master bus
);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT - 1);
    localparam logic [DW-1:0] CHK_PAT    = DW'({(DW/2){2'b01}});

    state_t        state_q, state_d;
    logic [2:0]    tt_q, tt_d;
    logic [2:0]    elem_q, elem_d;
    logic          opSel_q, opSel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    drain_q, drain_d;

    elem_t         cur;
    logic          opRead;
    logic          opInv;
    logic [DW-1:0] baseData;
    logic [DW-1:0] opData;
    logic          start;
    logic          running;
    logic [CW-1:0] failCnt;

    // Decode the current op from the element table. The checkerboard
    // background alternates with the address LSB.
    always_comb begin
        cur      = elemLookup(tt_q, elem_q);
        opRead   = opSel_q ? cur.rd1 : cur.rd0;
        opInv    = opSel_q ? cur.inv1 : cur.inv0;
        baseData = '0;
        if (tt_q == TT_CHKB) begin
            baseData = addr_q[0] ? ~CHK_PAT : CHK_PAT;
        end
        opData = baseData ^ {DW{opInv}};
    end

    // Next-state logic. MBISTEN low always returns to IDLE; TESTTYPE is
    // captured only on the IDLE exit edge. In RUN the second op of a
    // two-op element is issued before the address moves; at the end of
    // an element the address jumps to the start of the next one.
    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        elem_d  = elem_q;
        opSel_d = opSel_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        start   = 1'b0;
        if (!bus.MBISTEN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tt_d    = bus.TESTTYPE;
                    elem_d  = '0;
                    opSel_d = 1'b0;
                    addr_d  = '0;
                    drain_d = '0;
                    if (bus.TESTTYPE <= TT_MARCHC) begin
                        state_d = S_RUN;
                        start   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_RUN: begin
                    if (cur.twoOps && !opSel_q) begin
                        opSel_d = 1'b1;
                    end else begin
                        opSel_d = 1'b0;
                        if (addr_q == (cur.down ? '0 : LAST_ADDR)) begin
                            if (elem_q == elemCount(tt_q) - 3'd1) begin
                                state_d = S_DRAIN;
                            end else begin
                                elem_d = elem_q + 3'd1;
                                addr_d = elemDown(tt_q, elem_q + 3'd1) ? LAST_ADDR : '0;
                            end
                        end else begin
                            addr_d = cur.down ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
                default: begin
                    state_d = S_DONE;
                end
            endcase
        end
    end

    // FSM and sequencing registers.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            tt_q    <= '0;
            elem_q  <= '0;
            opSel_q <= 1'b0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            elem_q  <= elem_d;
            opSel_q <= opSel_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Strobes are gated by MBISTEN so an abort silences the bus in the
    // same cycle it is requested, not one edge later.
    assign running        = (state_q == S_RUN) && bus.MBISTEN;
    assign bus.iRead      = running && opRead;
    assign bus.iWrite     = running && !opRead;
    assign bus.ADDR_MBIST = addr_q;
    assign bus.DATA_MBIST = running ? opData : '0;
    assign bus.DONE       = (state_q == S_DONE);
    assign bus.RESULT     = (state_q == S_DONE) && (tt_q <= TT_MARCHC) && (failCnt == '0);
    assign bus.FAIL_CNT   = failCnt;

    mbist_cmp_pipe #(
        .DW     (DW),
        .AW     (AW),
        .RD_LAT (RD_LAT),
        .CW     (CW)
    ) u_cmp (
        .clk        (CLK),
        .nReset     (nRESET),
        .clear_i    (start),
        .flush_i    (!bus.MBISTEN),
        .rdValid_i  (bus.iRead),
        .expData_i  (opData),
        .addr_i     (addr_q),
        .dataDut_i  (bus.DATA_DUT),
        .failAddr_o (bus.FAIL_ADDR),
        .failData_o (bus.FAIL_DATA),
        .failCnt_o  (failCnt)
    );

endmodule

// File: tb/tb_mbist_march_engine.sv
// tb_mbist_march_engine: directed self-checking bench for mbist_march_engine.
// Instance A: DW=8, AW=8, DEPTH=256, RD_LAT=1 with an optional stuck-at-1
// on bit 3 of address 0x3C. Instance B: DEPTH=200, RD_LAT=3, fault-free.
module tb_mbist_march_engine;

    logic CLK;
    logic nRESET;
    logic faultEn;

    int nCompared;
    int nMismatched;

    int       runCycles;
    int       runOps;
    bit       runBoth;
    bit       runTimeout;
    int       maxAddr;
    logic [7:0] firstAddr;
    logic     firstWrite;
    logic [7:0] capAddr;
    logic     capRead;
    logic [7:0] wr0Log [2];
    logic [7:0] wr1Log [2];
    int       nWr0;
    int       nWr1;

    mbist_march_engine_if #(.DW(8), .AW(8), .CW(8)) busA ();
    mbist_march_engine_if #(.DW(8), .AW(8), .CW(8)) busB ();

    mbist_march_engine #(
        .DW(8), .AW(8), .DEPTH(256), .RD_LAT(1), .CW(8)
    ) dutA (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (busA)
    );

    mbist_march_engine #(
        .DW(8), .AW(8), .DEPTH(200), .RD_LAT(3), .CW(8)
    ) dutB (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (busB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model A: one cycle read latency, optional stuck-at-1 fault.
    logic [7:0] memA [256];
    logic [7:0] rdA;
    always @(posedge CLK) begin
        if (busA.iWrite) memA[busA.ADDR_MBIST] <= busA.DATA_MBIST;
        rdA <= memA[busA.ADDR_MBIST] |
               ((faultEn && busA.ADDR_MBIST == 8'h3C) ? 8'h08 : 8'h00);
    end
    assign busA.DATA_DUT = rdA;

    // SRAM model B: three cycle read latency.
    logic [7:0] memB [256];
    logic [7:0] rdB [3];
    always @(posedge CLK) begin
        if (busB.iWrite) memB[busB.ADDR_MBIST] <= busB.DATA_MBIST;
        rdB[0] <= memB[busB.ADDR_MBIST];
        rdB[1] <= rdB[0];
        rdB[2] <= rdB[1];
    end
    assign busB.DATA_DUT = rdB[2];

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Start a test on instance A (sel=0) or B (sel=1) and watch it cycle by
    // cycle until DONE, an abort point (ops observed) or the cycle budget.
    // TESTTYPE is scrambled right after the start edge to show it is latched.
    task automatic applyStimulus(input bit sel, input logic [2:0] tt, input int maxCycles,
                                 input int abortAt, input int capIdx);
        logic       w;
        logic       r;
        logic       done;
        logic [7:0] a;
        logic [7:0] d;
        if (sel ? busB.MBISTEN : busA.MBISTEN) begin
            if (sel) busB.MBISTEN = 1'b0; else busA.MBISTEN = 1'b0;
            @(negedge CLK);
        end
        runCycles = 0; runOps = 0; runBoth = 0; runTimeout = 0; maxAddr = 0;
        firstAddr = 8'hFF; firstWrite = 1'b0; capAddr = 8'h00; capRead = 1'b0;
        nWr0 = 0; nWr1 = 0;
        if (sel) begin
            busB.TESTTYPE = tt; busB.MBISTEN = 1'b1;
        end else begin
            busA.TESTTYPE = tt; busA.MBISTEN = 1'b1;
        end
        while (1) begin
            @(negedge CLK);
            runCycles++;
            if (runCycles == 1) begin
                if (sel) busB.TESTTYPE = 3'd6; else busA.TESTTYPE = 3'd6;
            end
            w    = sel ? busB.iWrite : busA.iWrite;
            r    = sel ? busB.iRead : busA.iRead;
            a    = sel ? busB.ADDR_MBIST : busA.ADDR_MBIST;
            d    = sel ? busB.DATA_MBIST : busA.DATA_MBIST;
            done = sel ? busB.DONE : busA.DONE;
            if (w && r) runBoth = 1'b1;
            if (w || r) begin
                if (runOps == 0) begin
                    firstAddr  = a;
                    firstWrite = w;
                end
                if (runOps == capIdx) begin
                    capAddr = a;
                    capRead = r;
                end
                if (int'(a) > maxAddr) maxAddr = int'(a);
                if (w && a == 8'h00 && nWr0 < 2) begin
                    wr0Log[nWr0] = d; nWr0++;
                end
                if (w && a == 8'h01 && nWr1 < 2) begin
                    wr1Log[nWr1] = d; nWr1++;
                end
                runOps++;
            end
            if (done) break;
            if (abortAt >= 0 && runOps == abortAt) break;
            if (runCycles >= maxCycles) begin
                runTimeout = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit anyStrobe;
        bit anyDone;

        nCompared = 0; nMismatched = 0;
        faultEn = 1'b0;
        nRESET = 1'b0;
        busA.MBISTEN = 1'b0; busA.TESTTYPE = 3'd0;
        busB.MBISTEN = 1'b0; busB.TESTTYPE = 3'd0;
        repeat (3) @(negedge CLK);

        $display("[TB] reset state");
        checkOutput("rstA_ctl", {busA.iWrite, busA.iRead, busA.DONE, busA.RESULT,
                                 busA.ADDR_MBIST, busA.DATA_MBIST}, 32'h0);
        checkOutput("rstA_res", {busA.FAIL_ADDR, busA.FAIL_DATA, busA.FAIL_CNT}, 32'h0);
        checkOutput("rstB_ctl", {busB.iWrite, busB.iRead, busB.DONE, busB.RESULT,
                                 busB.ADDR_MBIST, busB.DATA_MBIST}, 32'h0);
        checkOutput("rstB_res", {busB.FAIL_ADDR, busB.FAIL_DATA, busB.FAIL_CNT}, 32'h0);
        nRESET = 1'b1;

        $display("[TB] reserved TESTTYPE=5");
        applyStimulus(1'b0, 3'd5, 10, -1, 0);
        checkOutput("rsvd_cycles", runCycles, 1);
        checkOutput("rsvd_done_result", {busA.DONE, busA.RESULT}, 2'b10);
        checkOutput("rsvd_ops", runOps, 0);
        repeat (3) @(negedge CLK);
        checkOutput("rsvd_done_held", {busA.DONE, busA.iWrite, busA.iRead}, 3'b100);

        $display("[TB] Mscan");
        applyStimulus(1'b0, 3'd0, 1200, -1, 0);
        checkOutput("mscan_timeout", runTimeout, 0);
        checkOutput("mscan_ops", runOps, 1024);
        checkOutput("mscan_cycles", runCycles, 1026);
        checkOutput("mscan_result", {busA.DONE, busA.RESULT}, 2'b11);
        checkOutput("mscan_failcnt", busA.FAIL_CNT, 0);
        checkOutput("mscan_both", runBoth, 0);
        checkOutput("mscan_first", {firstWrite, firstAddr}, {1'b1, 8'h00});

        $display("[TB] checkerboard");
        applyStimulus(1'b0, 3'd1, 1200, -1, 0);
        checkOutput("chkb_ops", runOps, 1024);
        checkOutput("chkb_addr0_wr", {wr0Log[0], wr0Log[1]}, 16'h55AA);
        checkOutput("chkb_addr1_wr", {wr1Log[0], wr1Log[1]}, 16'hAA55);
        checkOutput("chkb_result", {busA.DONE, busA.RESULT}, 2'b11);

        $display("[TB] March C- with stuck-at-1 at 0x3C bit 3");
        faultEn = 1'b1;
        applyStimulus(1'b0, 3'd2, 3000, -1, 0);
        checkOutput("marchf_ops", runOps, 2560);
        checkOutput("marchf_cycles", runCycles, 2562);
        checkOutput("marchf_result", {busA.DONE, busA.RESULT}, 2'b10);
        checkOutput("marchf_addr", busA.FAIL_ADDR, 8'h3C);
        checkOutput("marchf_data", busA.FAIL_DATA, 8'h08);
        checkOutput("marchf_cnt", busA.FAIL_CNT, 3);
        checkOutput("marchf_both", runBoth, 0);

        $display("[TB] Mscan abort at op 500");
        applyStimulus(1'b0, 3'd0, 1200, 500, -1);
        checkOutput("abort_reached", {runTimeout, runOps[15:0]}, {1'b0, 16'd500});
        busA.MBISTEN = 1'b0;
        #1;
        checkOutput("abort_strobes", {busA.iWrite, busA.iRead}, 2'b00);
        anyStrobe = 1'b0; anyDone = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (busA.iWrite || busA.iRead) anyStrobe = 1'b1;
            if (busA.DONE) anyDone = 1'b1;
        end
        checkOutput("abort_quiet", {anyStrobe, anyDone}, 2'b00);
        checkOutput("abort_hold", {busA.FAIL_ADDR, busA.FAIL_DATA, busA.FAIL_CNT},
                    {8'h3C, 8'h08, 8'd1});
        faultEn = 1'b0;
        applyStimulus(1'b0, 3'd0, 1200, -1, -1);
        checkOutput("restart_first", {firstWrite, firstAddr}, {1'b1, 8'h00});
        checkOutput("restart_ops", runOps, 1024);
        checkOutput("restart_cycles", runCycles, 1026);
        checkOutput("restart_result", {busA.DONE, busA.RESULT, busA.FAIL_CNT}, {2'b11, 8'd0});

        $display("[TB] reset during March C-");
        faultEn = 1'b1;
        applyStimulus(1'b0, 3'd2, 3000, 600, -1);
        checkOutput("midrst_precnt", busA.FAIL_CNT, 1);
        nRESET = 1'b0;
        @(negedge CLK);
        checkOutput("midrst_ctl", {busA.iWrite, busA.iRead, busA.DONE}, 3'b000);
        checkOutput("midrst_res", {busA.FAIL_ADDR, busA.FAIL_DATA, busA.FAIL_CNT}, 32'h0);
        busA.MBISTEN = 1'b0;
        nRESET = 1'b1;
        faultEn = 1'b0;
        @(negedge CLK);

        $display("[TB] DEPTH=200 RD_LAT=3 March C-");
        applyStimulus(1'b1, 3'd2, 2200, -1, 1000);
        checkOutput("b_timeout", runTimeout, 0);
        checkOutput("b_ops", runOps, 2000);
        checkOutput("b_cycles", runCycles, 2004);
        checkOutput("b_maxaddr", maxAddr, 199);
        checkOutput("b_down_start", {capRead, capAddr}, {1'b1, 8'd199});
        checkOutput("b_result", {busB.DONE, busB.RESULT, busB.FAIL_CNT}, {2'b11, 8'd0});
        checkOutput("b_both", runBoth, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
